serial_word_collector: RTL and testbench

//  Downstream stage of the N-bit left shift register: samples its serial

---
 rtl/serial_word_collector.sv | 132 +++++++++++++
 tb/tb_serial_word_collector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_collector
//  Description : Reassembles MSB-first serial frames into N-bit words and
//                hands them out over a valid/ready handshake, with sticky
//                overrun and framing-error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         si,
  input  logic         word_ready,
  input  logic         clr_err,
  output logic [N-1:0] word,
  output logic         word_valid,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err
);

  localparam int              c_cw   = $clog2(N + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_nx;
  logic [N-1:0]    r_shreg;
  logic [N-1:0]    w_shreg_nx;
  logic [N-1:0]    w_cand;
  logic            w_done;
  logic            w_ferr_ev;
  logic            w_xfer;
  logic            w_load;
  logic            w_ovr_ev;

  logic [N-1:0]    r_word;
  logic            r_word_valid;
  logic            r_overrun;
  logic            r_frame_err;

  assign w_cand = {r_shreg[N-2:0], si};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shreg_nx = r_shreg;
    w_done     = 1'b0;
    w_ferr_ev  = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_shreg_nx = {{(N-1){1'b0}}, si};
            w_cnt_nx   = c_one;
            w_state_nx = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (start) begin
            // Mid-frame start: drop the partial word and resync on this bit.
            w_ferr_ev  = 1'b1;
            w_shreg_nx = {{(N-1){1'b0}}, si};
            w_cnt_nx   = c_one;
          end else begin
            w_shreg_nx = w_cand;
            w_cnt_nx   = r_cnt + c_one;
            if (r_cnt == c_last) begin
              w_done     = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = S_IDLE;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign w_xfer   = r_word_valid & word_ready;
  assign w_load   = w_done & (~r_word_valid | word_ready);
  assign w_ovr_ev = w_done & r_word_valid & ~word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shreg <= w_shreg_nx;

      if (w_load) begin
        r_word       <= w_cand;
        r_word_valid <= 1'b1;
      end else if (w_xfer) begin
        r_word_valid <= 1'b0;
      end

      // A new error event takes priority over a simultaneous clear.
      if (w_ovr_ev)     r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;

      if (w_ferr_ev)    r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign busy       = (r_state == S_SHIFT);
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_collector
//  Description : Directed and random bench for serial_word_collector against
//                a queue-based frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_collector;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         si = 1'b0;
  logic         word_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [N-1:0] word;
  logic         word_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  serial_word_collector #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .si         (si),
    .word_ready (word_ready),
    .clr_err    (clr_err),
    .word       (word),
    .word_valid (word_valid),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a frame is a queue of received bits; a word is complete
  // when the queue holds N bits, and it is packed MSB-first.
  bit           q[$];
  bit           m_inframe;
  logic [N-1:0] m_word;
  bit           m_valid, m_ovr, m_ferr;
  bit           rdy_v, clr_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit s, input bit d,
                       input bit rdy, input bit clr);
    bit           complete;
    bit           ovr_ev;
    bit           fe_ev;
    logic [N-1:0] cand;
    complete = 0; ovr_ev = 0; fe_ev = 0; cand = '0;
    if (r) begin
      q.delete(); m_inframe = 0; m_word = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
      return;
    end
    if (e) begin
      if (s) begin
        if (m_inframe) fe_ev = 1;
        q.delete();
        q.push_back(d);
        m_inframe = 1;
      end else if (m_inframe) begin
        q.push_back(d);
      end
      if (m_inframe && q.size() == N) begin
        complete = 1;
        foreach (q[i]) cand = {cand[N-2:0], q[i]};
        q.delete();
        m_inframe = 0;
      end
    end
    if (complete) begin
      if (!m_valid || rdy) begin
        m_word  = cand;
        m_valid = 1;
      end else begin
        ovr_ev = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (ovr_ev) m_ovr = 1; else if (clr) m_ovr = 0;
    if (fe_ev)  m_ferr = 1; else if (clr) m_ferr = 0;
  endtask

  task automatic tick(input bit r, input bit e, input bit s, input bit d);
    rst = r; en = e; start = s; si = d; word_ready = rdy_v; clr_err = clr_v;
    model(r, e, s, d, rdy_v, clr_v);
    @(posedge clk);
    #1;
    check("word",       32'(word),       32'(m_word));
    check("word_valid", 32'(word_valid), 32'(m_valid));
    check("busy",       32'(busy),       32'(m_inframe));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("frame_err",  32'(frame_err),  32'(m_ferr));
  endtask

  // Sends one frame; rdy_last is the ready level on the final bit.
  task automatic send_frame(input logic [N-1:0] w, input int maxgap,
                            input bit rdy_during, input bit rdy_last);
    for (int i = N - 1; i >= 0; i--) begin
      rdy_v = rdy_during;
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        for (int k = 0; k < g; k++) tick(0, 0, $urandom_range(1, 0), $urandom_range(1, 0));
      end
      rdy_v = (i == 0) ? rdy_last : rdy_during;
      tick(0, 1, (i == N - 1), w[i]);
    end
  endtask

  initial begin
    rdy_v = 0; clr_v = 0;
    tick(1, 0, 0, 0);
    check("reset_word", 32'(word), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // en every cycle, ready high
    send_frame(8'hA5, 0, 1, 1);
    check("t1_word", 32'(word), 32'hA5);
    check("t1_valid", 32'(word_valid), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);
    rdy_v = 1; tick(0, 0, 0, 0);

    // random gaps between bits
    send_frame(8'h3C, 3, 0, 0);
    check("t2_word", 32'(word), 32'h3C);
    check("t2_flags", 32'({overrun, frame_err}), 32'h0);
    rdy_v = 1; tick(0, 0, 0, 0);

    // overrun with consumer stalled
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 1, 0, 0);
    check("t3_word", 32'(word), 32'h11);
    check("t3_ovr", 32'(overrun), 32'h1);
    rdy_v = 1; tick(0, 0, 0, 0);
    check("t3_drained", 32'(word_valid), 32'h0);
    rdy_v = 0; clr_v = 1; tick(0, 0, 0, 0); clr_v = 0;
    check("t3_clr", 32'(overrun), 32'h0);

    // accept on the cycle the next word completes
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 0, 1);
    check("t4_word", 32'(word), 32'h22);
    check("t4_valid", 32'(word_valid), 32'h1);
    check("t4_ovr", 32'(overrun), 32'h0);
    rdy_v = 1; tick(0, 0, 0, 0);

    // framing error: start mid-frame restarts collection
    rdy_v = 1;
    tick(0, 1, 1, 1); tick(0, 1, 0, 1); tick(0, 1, 0, 1);
    send_frame(8'h00, 0, 1, 1);
    check("t5_ferr", 32'(frame_err), 32'h1);
    check("t5_word", 32'(word), 32'h00);

    // clear-vs-event priority: clear while a frame error occurs
    tick(0, 1, 1, 0);
    clr_v = 1; tick(0, 1, 1, 1); clr_v = 0;
    check("ferr_wins", 32'(frame_err), 32'h1);
    clr_v = 1; tick(0, 0, 0, 0); clr_v = 0;

    // reset mid-frame
    for (int i = 7; i >= 3; i--) tick(0, 1, (i == 7), 8'hA5 >> i);
    tick(1, 0, 0, 0);
    check("t6_rst", 32'({word, word_valid, busy, overrun, frame_err}), 32'h0);
    send_frame(8'h5A, 0, 1, 1);
    check("t6_word", 32'(word), 32'h5A);
    check("t6_flags", 32'({overrun, frame_err}), 32'h0);

    // random traffic
    for (int it = 0; it < 600; it++) begin
      bit rr;
      rr    = ($urandom_range(199, 0) == 0);
      rdy_v = ($urandom_range(3, 0) != 0);
      clr_v = ($urandom_range(15, 0) == 0);
      tick(rr, $urandom_range(2, 0) != 0, $urandom_range(9, 0) == 0, $urandom_range(1, 0));
    end
    clr_v = 0; rdy_v = 1;
    for (int it = 0; it < 20; it++) send_frame(8'($urandom), 2, $urandom_range(1, 0), $urandom_range(1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
